// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding, requester indices
// and the encoding of the "last granted" pointer.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_C = 2'd1,
    BUSY_H = 2'd2
  } arb_state_e;

  localparam int unsigned REQ_CORE = 0;
  localparam int unsigned REQ_HOST = 1;

  localparam logic PTR_CORE = 1'b0;
  localparam logic PTR_HOST = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone candidate always wins; on a tie the
// requester that was NOT granted last wins. Purely combinational.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] cand_i,
  input  logic       last_i,
  output logic [1:0] win_o
);

  // One-hot winner selection.
  always_comb begin
    win_o = 2'b00;
    case (cand_i)
      2'b01:   win_o = 2'b01;
      2'b10:   win_o = 2'b10;
      2'b11:   win_o = (last_i == PTR_HOST) ? 2'b01 : 2'b10;
      default: win_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core and the host/loader.
// Define DMEM_ARB_HOST_PRIO_EN to make the host win every tie (no pointer).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_e        state_q, state_d;
  logic              c_rvalid_q, h_rvalid_q;
  logic [DATA_W-1:0] c_rdata_q, h_rdata_q;
  logic [1:0]        cand_s, win_s;
  logic              last_s;
  logic              mux_we_s;

  assign c_gnt   = (state_q == BUSY_C);
  assign h_gnt   = (state_q == BUSY_H);
  assign c_stall = c_req & ~c_gnt;

  // A port granted this cycle may not compete for the next one.
  assign cand_s[REQ_CORE] = c_req & ~c_gnt;
  assign cand_s[REQ_HOST] = h_req & ~h_gnt;

`ifdef DMEM_ARB_HOST_PRIO_EN
  assign last_s = PTR_CORE;
`else
  logic ptr_q, ptr_d;

  // Pointer next-state: remember whoever wins this cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (win_s[REQ_CORE]) begin
      ptr_d = PTR_CORE;
    end else if (win_s[REQ_HOST]) begin
      ptr_d = PTR_HOST;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; resets to host so the core takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= PTR_HOST;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign last_s = ptr_q;
`endif

  rr_arb2 u_rr_arb2 (
    .cand_i (cand_s),
    .last_i (last_s),
    .win_o  (win_s)
  );

  // Next-state decode from the one-hot winner.
  always_comb begin
    state_d = IDLE;
    if (win_s[REQ_CORE]) begin
      state_d = BUSY_C;
    end else if (win_s[REQ_HOST]) begin
      state_d = BUSY_H;
    end else begin
      state_d = IDLE;
    end
  end

  // Memory port mux driven by the current grant.
  always_comb begin
    m_addr   = {ADDR_W{1'b0}};
    m_wdata  = {DATA_W{1'b0}};
    mux_we_s = 1'b0;
    case (state_q)
      BUSY_C: begin
        m_addr   = c_addr;
        m_wdata  = c_wdata;
        mux_we_s = c_we;
      end
      BUSY_H: begin
        m_addr   = h_addr;
        m_wdata  = h_wdata;
        mux_we_s = h_we;
      end
      default: begin
        m_addr   = {ADDR_W{1'b0}};
        m_wdata  = {DATA_W{1'b0}};
        mux_we_s = 1'b0;
      end
    endcase
  end

  // Reset aborts an in-flight write before it reaches the memory edge.
  assign m_we = mux_we_s & ~reset;

  // State and read-return registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      c_rdata_q  <= {DATA_W{1'b0}};
      h_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      c_rvalid_q <= c_gnt & ~c_we;
      h_rvalid_q <= h_gnt & ~h_we;
      if (c_gnt & ~c_we) c_rdata_q <= m_rdata;
      if (h_gnt & ~h_we) h_rdata_q <= m_rdata;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign h_rvalid = h_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign h_rdata  = h_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a transaction-level
// model with a shadow memory; honours DMEM_ARB_HOST_PRIO_EN for tie expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, h_req, h_we;
  logic [15:0] c_addr, c_wdata, h_addr, h_wdata;
  logic        c_gnt, c_rvalid, c_stall, h_gnt, h_rvalid, m_we;
  logic [15:0] c_rdata, h_rdata, m_addr, m_wdata, m_rdata;

  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int total = 0;
  int bad   = 0;

  // random-phase model state
  logic        e_cg, e_hg, p_cg, p_hg, e_crv, e_hrv, n_crv, n_hrv, last_h;
  logic        want_c, want_h;
  logic [15:0] e_crd, e_hrd;
  int          winner;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata)
  );

  assign m_rdata = mem[m_addr[7:0]];

  always @(posedge clk) begin
    if (m_we) mem[m_addr[7:0]] <= m_wdata;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 1'b0; c_addr = 16'h0000; c_wdata = 16'h0000;
    h_req = 1'b0; h_we = 1'b0; h_addr = 16'h0000; h_wdata = 16'h0000;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pl_we = 1'b0; pl_addr = 8'h00; pl_data = 16'h0000;
    idle_inputs();
    for (int a = 0; a < 256; a++) preload(8'(a), 16'($urandom));
    preload(8'h10, 16'hBEEF);
    preload(8'h03, 16'h0BAD);

    // core read alone, plus reset-state checks
    do_reset();
    #1;
    chk("rst_c_gnt", c_gnt, 1'b0);     chk("rst_h_gnt", h_gnt, 1'b0);
    chk("rst_c_rv", c_rvalid, 1'b0);   chk("rst_h_rv", h_rvalid, 1'b0);
    chk("rst_c_rd", c_rdata, 16'h0);   chk("rst_h_rd", h_rdata, 16'h0);
    chk("rst_m_we", m_we, 1'b0);       chk("rst_m_addr", m_addr, 16'h0);
    chk("rst_m_wdata", m_wdata, 16'h0); chk("rst_stall", c_stall, 1'b0);
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
    #1;
    chk("rd_c0_stall", c_stall, 1'b1); chk("rd_c0_gnt", c_gnt, 1'b0);
    tick(); #1;
    chk("rd_c1_gnt", c_gnt, 1'b1);     chk("rd_c1_stall", c_stall, 1'b0);
    chk("rd_c1_maddr", m_addr, 16'h0010); chk("rd_c1_mwe", m_we, 1'b0);
    tick(); c_req = 1'b0; #1;
    chk("rd_c2_rv", c_rvalid, 1'b1);   chk("rd_c2_rd", c_rdata, 16'hBEEF);
    chk("rd_c2_gnt", c_gnt, 1'b0);
    tick(); #1;
    chk("rd_c3_rv", c_rvalid, 1'b0);   chk("rd_c3_hold", c_rdata, 16'hBEEF);

    // simultaneous core read / host write after reset
    do_reset(); #1;
    chk("sim_rst_rd", c_rdata, 16'h0);
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0001;
    h_req = 1'b1; h_we = 1'b1; h_addr = 16'h0002; h_wdata = 16'h1234;
    #1;
    chk("sim_c0_gnt", c_gnt | h_gnt, 1'b0);
`ifdef DMEM_ARB_HOST_PRIO_EN
    tick(); #1;
    chk("sim_c1_hgnt", h_gnt, 1'b1);   chk("sim_c1_mwe", m_we, 1'b1);
    tick(); h_req = 1'b0; #1;
    chk("sim_c2_cgnt", c_gnt, 1'b1);   chk("sim_c2_maddr", m_addr, 16'h0001);
    chk("sim_c2_mem", mem[2], 16'h1234);
    tick(); c_req = 1'b0; #1;
    chk("sim_c3_rv", c_rvalid, 1'b1);  chk("sim_c3_rd", c_rdata, ref_mem[1]);
`else
    tick(); #1;
    chk("sim_c1_cgnt", c_gnt, 1'b1);   chk("sim_c1_hgnt", h_gnt, 1'b0);
    tick(); c_req = 1'b0; #1;
    chk("sim_c2_hgnt", h_gnt, 1'b1);   chk("sim_c2_mwe", m_we, 1'b1);
    chk("sim_c2_maddr", m_addr, 16'h0002);
    chk("sim_c2_rv", c_rvalid, 1'b1);  chk("sim_c2_rd", c_rdata, ref_mem[1]);
    tick(); h_req = 1'b0; #1;
    chk("sim_c3_mem", mem[2], 16'h1234); chk("sim_c3_hrv", h_rvalid, 1'b0);
`endif
    ref_mem[2] = 16'h1234;

    // host write then core read of the same address
    do_reset();
    h_req = 1'b1; h_we = 1'b1; h_addr = 16'h00FF; h_wdata = 16'hA5A5;
    tick(); c_req = 1'b1; c_we = 1'b0; c_addr = 16'h00FF; #1;
    chk("raw_c1_hgnt", h_gnt, 1'b1);   chk("raw_c1_cgnt", c_gnt, 1'b0);
    tick(); h_req = 1'b0; #1;
    chk("raw_c2_cgnt", c_gnt, 1'b1);   chk("raw_c2_hrv", h_rvalid, 1'b0);
    tick(); c_req = 1'b0; #1;
    chk("raw_c3_rv", c_rvalid, 1'b1);  chk("raw_c3_rd", c_rdata, 16'hA5A5);
    ref_mem[8'hFF] = 16'hA5A5;

    // reset during a host write
    do_reset();
    h_req = 1'b1; h_we = 1'b1; h_addr = 16'h0003; h_wdata = 16'hDEAD;
    tick(); reset = 1'b1; #1;
    chk("abort_c1_hgnt", h_gnt, 1'b1); chk("abort_c1_mwe", m_we, 1'b0);
    tick(); reset = 1'b0; h_req = 1'b0; #1;
    chk("abort_mem", mem[3], 16'h0BAD);
    chk("abort_gnt", {c_gnt, h_gnt}, 2'b00);
    chk("abort_rv", {c_rvalid, h_rvalid}, 2'b00);
    chk("abort_maddr", m_addr, 16'h0000);

    // continuous requests from both ports
    do_reset();
    c_req = 1'b1; c_addr = 16'h0020; h_req = 1'b1; h_addr = 16'h0021;
    for (int k = 0; k < 9; k++) begin
      #1;
`ifdef DMEM_ARB_HOST_PRIO_EN
      chk("alt_cgnt", c_gnt, (k > 0) && (k % 2 == 0));
      chk("alt_hgnt", h_gnt, (k % 2 == 1));
`else
      chk("alt_cgnt", c_gnt, (k % 2 == 1));
      chk("alt_hgnt", h_gnt, (k > 0) && (k % 2 == 0));
`endif
      if (k > 0) chk("alt_maddr", m_addr, (c_gnt ? 16'h0020 : 16'h0021));
      tick();
    end
    idle_inputs();

    // randomized traffic against the shadow-memory model
    do_reset();
    e_cg = 1'b0; e_hg = 1'b0; p_cg = 1'b0; p_hg = 1'b0;
    e_crv = 1'b0; e_hrv = 1'b0; e_crd = 16'h0; e_hrd = 16'h0; last_h = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (c_req && p_cg) c_req = 1'b0;
      if (c_req) begin
        if (!e_cg && $urandom_range(7, 0) == 0) c_req = 1'b0;
      end else if ($urandom_range(1, 0) == 1) begin
        c_req = 1'b1; c_we = 1'($urandom_range(1, 0));
        c_addr = 16'($urandom_range(7, 0)); c_wdata = 16'($urandom);
      end
      if (h_req && p_hg) h_req = 1'b0;
      if (h_req) begin
        if (!e_hg && $urandom_range(7, 0) == 0) h_req = 1'b0;
      end else if ($urandom_range(1, 0) == 1) begin
        h_req = 1'b1; h_we = 1'($urandom_range(1, 0));
        h_addr = 16'($urandom_range(7, 0)); h_wdata = 16'($urandom);
      end
      #1;
      chk("rnd_cgnt", c_gnt, e_cg);     chk("rnd_hgnt", h_gnt, e_hg);
      chk("rnd_stall", c_stall, c_req & ~e_cg);
      chk("rnd_crv", c_rvalid, e_crv);  chk("rnd_hrv", h_rvalid, e_hrv);
      chk("rnd_crd", c_rdata, e_crd);   chk("rnd_hrd", h_rdata, e_hrd);
      if (e_cg) chk("rnd_mwe_c", m_we, c_we);
      if (e_hg) chk("rnd_mwe_h", m_we, h_we);

      n_crv = e_cg && !c_we;
      n_hrv = e_hg && !h_we;
      if (n_crv) e_crd = ref_mem[c_addr[7:0]];
      if (n_hrv) e_hrd = ref_mem[h_addr[7:0]];
      if (e_cg && c_we) ref_mem[c_addr[7:0]] = c_wdata;
      if (e_hg && h_we) ref_mem[h_addr[7:0]] = h_wdata;
      want_c = c_req && !e_cg;
      want_h = h_req && !e_hg;
      if (want_c && want_h) begin
`ifdef DMEM_ARB_HOST_PRIO_EN
        winner = 2;
`else
        winner = last_h ? 1 : 2;
`endif
      end else begin
        winner = want_c ? 1 : (want_h ? 2 : 0);
      end
      if (winner != 0) last_h = (winner == 2);
      p_cg = e_cg; p_hg = e_hg;
      e_cg = (winner == 1); e_hg = (winner == 2);
      e_crv = n_crv; e_hrv = n_hrv;
      tick();
    end
    for (int a = 0; a < 8; a++) chk("rnd_mem", mem[a], ref_mem[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
